// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXE/MEM/WB, drives datapath
// selects and write strobes, stalls on mem_ready and counts retired instructions.
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic [1:0]       regdst_sel,
  output logic             alusrc_sel,
  output logic [1:0]       memtoreg_sel,
  output logic [1:0]       ext_op,
  output logic [2:0]       alu_op,
  output logic [2:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXE    = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;

  logic [2:0] next_state;
  logic       r_type, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic       is_lw, is_sw, is_beq, is_j, is_jal, is_legal, in_instr;

  assign r_type   = (opcode == OP_RTYPE);
  assign is_addu  = r_type && (funct == FN_ADDU);
  assign is_subu  = r_type && (funct == FN_SUBU);
  assign is_jr    = r_type && (funct == FN_JR);
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_legal = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw |
                    is_sw | is_beq | is_j | is_jal;

  // Selects follow the decoded instruction from DECODE through WB; the IR holds
  // opcode/funct steady, so they stay stable for the whole instruction.
  assign in_instr = (state == S_DECODE) || (state == S_EXE) ||
                    (state == S_MEM)    || (state == S_WB);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    regdst_sel   = 2'b00;
    alusrc_sel   = 1'b0;
    memtoreg_sel = 2'b00;
    ext_op       = 2'b00;
    alu_op       = ALU_ADD;
    if (in_instr) begin
      if (is_addu) begin
        regdst_sel = 2'b01;
        alu_op     = ALU_ADD;
      end else if (is_subu) begin
        regdst_sel = 2'b01;
        alu_op     = ALU_SUB;
      end else if (is_ori) begin
        alusrc_sel = 1'b1;
        ext_op     = 2'b00;
        alu_op     = ALU_OR;
      end else if (is_lui) begin
        alusrc_sel = 1'b1;
        ext_op     = 2'b10;
        alu_op     = ALU_OR;
      end else if (is_lw || is_sw) begin
        alusrc_sel   = 1'b1;
        ext_op       = 2'b01;
        alu_op       = ALU_ADD;
        memtoreg_sel = is_lw ? 2'b01 : 2'b00;
      end else if (is_beq) begin
        ext_op = 2'b01;
        alu_op = ALU_SUB;
      end else if (is_jal) begin
        regdst_sel   = 2'b10;
        memtoreg_sel = 2'b10;
      end
    end
  end

  // Strobes are decoded from the state register, so an asynchronous reset
  // clears them immediately, including a memory request held during a stall.
  always_comb begin
    next_state = state;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    npc_sel    = 2'b00;
    reg_we     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        if (is_j || is_jal || is_jr) begin
          pc_we      = 1'b1;
          npc_sel    = is_jr ? 2'b11 : 2'b10;
          reg_we     = is_jal;
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (!is_legal) begin
          illegal    = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (is_beq) begin
          npc_sel    = 2'b01;
          pc_we      = zero;
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (is_lw || is_sw) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        mem_re = is_lw;
        mem_we = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            next_state = S_WB;
          end else begin
            retire     = is_sw;
            next_state = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected outputs are queued when an
// instruction is issued and compared cycle by cycle as the FSM steps through it.
module tb_mc_ctrl_fsm;

  localparam int CNT_W = 3;

  typedef struct packed {
    logic [2:0] state;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic [1:0] regdst;
    logic       alusrc;
    logic [1:0] memtoreg;
    logic [1:0] ext;
    logic [2:0] alu;
    logic       retire;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    outs_t       exp;
    logic [63:0] tag;
  } cyc_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             ir_we, pc_we, reg_we, mem_re, mem_we, alusrc_sel, retire, illegal;
  logic [1:0]       npc_sel, regdst_sel, memtoreg_sel, ext_op;
  logic [2:0]       alu_op, state;
  logic [CNT_W-1:0] instr_cnt;
  outs_t            act;

  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  cyc_t             sb[$];

  mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .regdst_sel(regdst_sel),
    .alusrc_sel(alusrc_sel), .memtoreg_sel(memtoreg_sel), .ext_op(ext_op),
    .alu_op(alu_op), .state(state), .retire(retire), .illegal(illegal),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign act = '{state: state, ir_we: ir_we, pc_we: pc_we, npc_sel: npc_sel,
                 reg_we: reg_we, mem_re: mem_re, mem_we: mem_we, regdst: regdst_sel,
                 alusrc: alusrc_sel, memtoreg: memtoreg_sel, ext: ext_op,
                 alu: alu_op, retire: retire, illegal: illegal};

  // Datapath selects expected while an instruction occupies DECODE..WB.
  function automatic outs_t dec_sel(input logic [5:0] op, input logic [5:0] fn);
    outs_t o = '0;
    if (op == 6'b000000 && fn == 6'b100001) begin o.regdst = 2'b01; o.alu = 3'b000; end
    if (op == 6'b000000 && fn == 6'b100011) begin o.regdst = 2'b01; o.alu = 3'b001; end
    if (op == 6'b001101) begin o.alusrc = 1'b1; o.ext = 2'b00; o.alu = 3'b010; end
    if (op == 6'b001111) begin o.alusrc = 1'b1; o.ext = 2'b10; o.alu = 3'b010; end
    if (op == 6'b100011) begin o.alusrc = 1'b1; o.ext = 2'b01; o.memtoreg = 2'b01; end
    if (op == 6'b101011) begin o.alusrc = 1'b1; o.ext = 2'b01; end
    if (op == 6'b000100) begin o.ext = 2'b01; o.alu = 3'b001; end
    if (op == 6'b000011) begin o.regdst = 2'b10; o.memtoreg = 2'b10; end
    return o;
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic mr, input outs_t e, input logic [63:0] tag);
    cyc_t c;
    c.op = op; c.fn = fn; c.z = z; c.mr = mr; c.exp = e; c.tag = tag;
    sb.push_back(c);
  endtask

  // Queues one cycle record per expected FSM cycle of the instruction.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int stalls, input logic mr_other);
    outs_t s = dec_sel(op, fn);
    outs_t e;
    logic rt   = (op == 6'b000000);
    logic addu = rt && fn == 6'b100001;
    logic subu = rt && fn == 6'b100011;
    logic jr   = rt && fn == 6'b001000;
    logic j    = (op == 6'b000010);
    logic jal  = (op == 6'b000011);
    logic lw   = (op == 6'b100011);
    logic sw   = (op == 6'b101011);
    logic beq  = (op == 6'b000100);
    logic ok   = addu | subu | jr | j | jal | lw | sw | beq |
                 (op == 6'b001101) | (op == 6'b001111);
    e = '0; e.state = 3'd1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    push(op, fn, z, mr_other, e, "FETCH");
    e = s; e.state = 3'd2;
    if (!ok) begin
      e = '0; e.state = 3'd2; e.illegal = 1'b1;
      push(op, fn, z, mr_other, e, "DEC_ILL");
      return;
    end
    if (j || jal || jr) begin
      e.pc_we = 1'b1; e.npc_sel = jr ? 2'b11 : 2'b10; e.reg_we = jal; e.retire = 1'b1;
      push(op, fn, z, mr_other, e, "DEC_JMP");
      return;
    end
    push(op, fn, z, mr_other, e, "DECODE");
    e = s; e.state = 3'd3;
    if (beq) begin
      e.npc_sel = 2'b01; e.pc_we = z; e.retire = 1'b1;
      push(op, fn, z, mr_other, e, "EXE_BEQ");
      return;
    end
    push(op, fn, z, mr_other, e, "EXE");
    if (lw || sw) begin
      for (int i = 0; i <= stalls; i++) begin
        e = s; e.state = 3'd4; e.mem_re = lw; e.mem_we = sw;
        e.retire = sw && (i == stalls);
        push(op, fn, z, (i == stalls), e, "MEM");
      end
      if (sw) return;
    end
    e = s; e.state = 3'd5; e.reg_we = 1'b1; e.retire = 1'b1;
    push(op, fn, z, mr_other, e, "WB");
  endtask

  task automatic push_idle();
    outs_t e = '0;
    push(6'b100011, 6'd0, 1'b0, 1'b1, e, "IDLE");
  endtask

  // Pops up to n records, one per clock, driving stimulus and comparing outputs.
  task automatic drain(input int n);
    cyc_t c;
    for (int k = 0; k < n && sb.size() > 0; k++) begin
      @(negedge clk);
      c = sb.pop_front();
      opcode = c.op; funct = c.fn; zero = c.z; mem_ready = c.mr;
      #1;
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %0s outputs: got %h expected %h", c.tag, act, c.exp);
      end
      checks++;
      if (instr_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL %0s instr_cnt: got %0d expected %0d", c.tag, instr_cnt, exp_cnt);
      end
      if (c.exp.retire) exp_cnt = exp_cnt + 1'b1;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    push_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'b101011; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (act !== outs_t'('0) || instr_cnt !== '0) begin
      failures++;
      $display("FAIL reset_state: got %h cnt %0d expected 0 cnt 0", act, instr_cnt);
    end
    exp_cnt = '0;
    release_reset();
  endtask

  task automatic test_addu();
    issue(6'b000000, 6'b100001, 1'b0, 0, 1'b0);
    drain(sb.size());
  endtask

  task automatic test_lw_stall();
    issue(6'b100011, 6'b000000, 1'b0, 3, 1'b1);
    drain(sb.size());
  endtask

  task automatic test_beq();
    issue(6'b000100, 6'b000000, 1'b1, 0, 1'b0);
    issue(6'b000100, 6'b000000, 1'b0, 0, 1'b1);
    drain(sb.size());
  endtask

  task automatic test_jumps();
    issue(6'b000011, 6'b000000, 1'b0, 0, 1'b1);
    issue(6'b000010, 6'b000000, 1'b0, 0, 1'b0);
    issue(6'b000000, 6'b001000, 1'b0, 0, 1'b1);
    drain(sb.size());
  endtask

  task automatic test_illegal();
    issue(6'b111111, 6'b000000, 1'b0, 0, 1'b1);
    issue(6'b000000, 6'b000000, 1'b0, 0, 1'b0);
    drain(sb.size());
  endtask

  // Mixed sequence long enough to wrap the narrow retire counter.
  task automatic test_back_to_back();
    issue(6'b001101, 6'b000000, 1'b0, 0, 1'b1);
    issue(6'b001111, 6'b000000, 1'b0, 0, 1'b0);
    issue(6'b101011, 6'b000000, 1'b0, 1, 1'b1);
    issue(6'b000000, 6'b100011, 1'b1, 0, 1'b1);
    issue(6'b100011, 6'b000000, 1'b0, 0, 1'b0);
    issue(6'b000000, 6'b100001, 1'b0, 0, 1'b1);
    drain(sb.size());
  endtask

  task automatic test_reset_mid_stall();
    issue(6'b101011, 6'b000000, 1'b0, 10, 1'b0);
    drain(5);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || state !== 3'd0 || instr_cnt !== '0) begin
      failures++;
      $display("FAIL reset_mid_stall: got mem_we %b state %0d cnt %0d expected 0 0 0",
               mem_we, state, instr_cnt);
    end
    sb.delete();
    exp_cnt = '0;
    release_reset();
    issue(6'b000000, 6'b100001, 1'b0, 0, 1'b0);
    drain(sb.size());
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_stall();
    test_beq();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_reset_mid_stall();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control unit for the MIPS datapath. It sequences one instruction at a time through FETCH/DECODE/EXE/MEM/WB.
- It drives the select lines of the datapath muxes (RegDst 5-bit 3-way, ALUSrc 32-bit 2-way, MemtoReg 32-bit 3-way), the next-PC select, and all write strobes.
- It stalls in MEM on a data-memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, sampled in EXE
- mem_ready  in  1  data memory has completed the access this cycle
- ir_we  out  1  latch instruction into IR
- pc_we  out  1  PC write enable
- npc_sel  out  2  00 PC+4, 01 branch target, 10 j/jal target, 11 rs (jr)
- reg_we  out  1  register file write
- mem_re  out  1  data memory read request
- mem_we  out  1  data memory write request
- regdst_sel  out  2  00 rt, 01 rd, 10 $31
- alusrc_sel  out  1  0 rt data, 1 extended immediate
- memtoreg_sel  out  2  00 ALU result, 01 memory data, 10 PC+4
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16
- alu_op  out  3  000 add, 001 sub, 010 or
- state  out  3  current state (debug)
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct
- instr_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- While rst_n=0:
  - state=IDLE(0), instr_cnt=0.
  - All strobes, selects, retire and illegal are 0.
- After rst_n deasserts: IDLE lasts exactly 1 cycle, then FETCH.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXE 3, MEM 4, WB 5. Values 6 and 7 go to IDLE.
- Supported instructions:
  - R-type (op 000000) with funct addu 100001, subu 100011, jr 001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Selects and alu_op:
  - Combinational from opcode/funct in DECODE, EXE, MEM and WB.
  - Forced to 0 in IDLE and FETCH.
  - Held stable for the whole instruction.
- Decode table:
  - addu: regdst 01, alusrc 0, alu add.
  - subu: regdst 01, alusrc 0, alu sub.
  - ori: regdst 00, alusrc 1, ext 00, alu or.
  - lui: regdst 00, alusrc 1, ext 10, alu or.
  - lw/sw: alusrc 1, ext 01, alu add; lw also regdst 00, memtoreg 01.
  - beq: alusrc 0, ext 01, alu sub.
  - jal: regdst 10, memtoreg 10.
- FETCH: ir_we=1, pc_we=1, npc_sel=00; next DECODE.
- DECODE:
  - j: pc_we=1, npc_sel=10, retire=1; next FETCH.
  - jal: pc_we=1, npc_sel=10, reg_we=1, retire=1; next FETCH.
  - jr: pc_we=1, npc_sel=11, retire=1; next FETCH.
  - Unsupported opcode/funct: illegal=1, retire=0, no writes; next FETCH (executes as a nop).
  - Others: next EXE.
- EXE:
  - beq: npc_sel=01, pc_we=zero, retire=1; next FETCH.
  - lw/sw: next MEM.
  - addu/subu/ori/lui: next WB.
- MEM:
  - lw holds mem_re=1; sw holds mem_we=1; the request stays asserted every cycle until mem_ready=1.
  - mem_ready=1 with lw: next WB.
  - mem_ready=1 with sw: retire=1; next FETCH.
  - mem_ready=0: stay in MEM, with no limit on stall length.
  - mem_ready outside MEM is ignored.
- WB: reg_we=1, retire=1; next FETCH.
- Latency in cycles:
  - j/jal/jr 2, beq 3.
  - addu/subu/ori/lui 4.
  - sw 4+stalls, lw 5+stalls.
- instr_cnt: increments on the clock edge that ends each cycle with retire=1; wraps from 2^CNT_W-1 to 0.
- Reset mid-instruction, including during a MEM stall: all outputs drop to 0 immediately (asynchronously); the pending request is abandoned and instr_cnt is cleared.
- Strobe exclusivity: reg_we and mem_we are never both 1; pc_we and ir_we are both 1 only in FETCH.

Test Plan:
- Reset release, then IR=addu (000000/100021... funct 100001), mem_ready=0 -> state 0,1,2,3,5,1; regdst 01 and reg_we=1 only in WB; retire pulses once; instr_cnt=1.
- lw (100011), mem_ready low 3 cycles -> MEM held 4 cycles with mem_re=1 throughout; then WB with memtoreg 01, regdst 00, ext 01; total 8 cycles.
- beq with zero=1, then with zero=0 -> EXE has npc_sel=01, pc_we=1 and pc_we=0 respectively; both take 3 cycles.
- jal -> DECODE has pc_we=1, npc_sel=10, reg_we=1, regdst 10, memtoreg 10; FETCH follows; 2 cycles.
- Opcode 111111 -> illegal pulses 1 cycle in DECODE; no writes; instr_cnt unchanged.
- sw stalled in MEM, rst_n pulsed low -> mem_we drops to 0 without waiting for clk; state=0 and instr_cnt=0; recovers to FETCH after 1 IDLE cycle.
